// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the two-port AXI read arbiter: FSM states, owner type and AR IDs.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [3:0] ARID_I = 4'd0;
   localparam logic [3:0] ARID_D = 4'd1;

endpackage

// File: rtl/axi_rd_beat_chk.sv
// Beat counter for the granted read burst plus a sticky rlast/length mismatch flag.
module axi_rd_beat_chk (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] arlen,
   input  logic       beat,
   input  logic       last,
   output logic [7:0] count,
   output logic       len_err
);

   logic [7:0] exp_len;

   // count holds the index of the next beat, so the final beat must arrive at count == exp_len
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 8'd0;
         exp_len <= 8'd0;
         len_err <= 1'b0;
      end else if (start) begin
         count   <= 8'd0;
         exp_len <= arlen;
      end else if (beat) begin
         if (count != 8'hff) count <= count + 8'd1;
         if (last != (count == exp_len)) len_err <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-port (I/D cache) AXI read arbiter with one outstanding transaction.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise D-port has fixed priority.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_araddr,
   input  logic [7:0]        i_arlen,
   input  logic [2:0]        i_arsize,
   input  logic              i_arvalid,
   output logic              i_arready,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic              i_rlast,
   input  logic              i_rready,
   input  logic [ADDR_W-1:0] d_araddr,
   input  logic [7:0]        d_arlen,
   input  logic [2:0]        d_arsize,
   input  logic              d_arvalid,
   output logic              d_arready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_rlast,
   input  logic              d_rready,
   output logic [3:0]        m_arid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [7:0]        m_arlen,
   output logic [2:0]        m_arsize,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_rlast,
   output logic              m_rready,
   output logic              len_err,
   output logic [1:0]        dbg_state,
   output logic [7:0]        dbg_beat_cnt
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and AR fields are held stable by the requester while arvalid is high.

   arb_state_t state, state_nxt;
   owner_t     owner, owner_nxt, pick;
   logic       ar_hs, r_beat;

`ifdef ARB_RR_EN
   owner_t last_win;

   always_ff @(posedge clk) begin
      if (rst)        last_win <= OWN_I;
      else if (ar_hs) last_win <= owner;
   end

   always_comb begin
      pick = OWN_I;
      if (i_arvalid && d_arvalid) pick = (last_win == OWN_D) ? OWN_I : OWN_D;
      else if (d_arvalid)         pick = OWN_D;
   end
`else
   always_comb begin
      pick = OWN_I;
      if (d_arvalid) pick = OWN_D;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_I;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      m_arid    = ARID_I;
      m_araddr  = i_araddr;
      m_arlen   = i_arlen;
      m_arsize  = i_arsize;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      i_arready = 1'b0;
      d_arready = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rlast   = 1'b0;
      d_rlast   = 1'b0;
      if (owner == OWN_D) begin
         m_arid   = ARID_D;
         m_araddr = d_araddr;
         m_arlen  = d_arlen;
         m_arsize = d_arsize;
      end
      case (state)
         IDLE: begin
            if (i_arvalid || d_arvalid) begin
               owner_nxt = pick;
               state_nxt = AR;
            end
         end
         AR: begin
            m_arvalid = (owner == OWN_D) ? d_arvalid : i_arvalid;
            if (owner == OWN_D) d_arready = m_arready;
            else                i_arready = m_arready;
            // A requester withdrawing its request releases the bus without issuing anything
            if (!m_arvalid)     state_nxt = IDLE;
            else if (m_arready) state_nxt = R;
         end
         R: begin
            m_rready = (owner == OWN_D) ? d_rready : i_rready;
            if (owner == OWN_D) begin
               d_rvalid = m_rvalid;
               d_rlast  = m_rlast;
            end else begin
               i_rvalid = m_rvalid;
               i_rlast  = m_rlast;
            end
            if (m_rvalid && m_rready && m_rlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ar_hs     = (state == AR) && m_arvalid && m_arready;
   assign r_beat    = (state == R) && m_rvalid && m_rready;
   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;
   assign dbg_state = state;

   axi_rd_beat_chk u_beat_chk (
      .clk     (clk),
      .rst     (rst),
      .start   (ar_hs),
      .arlen   (m_arlen),
      .beat    (r_beat),
      .last    (m_rlast),
      .count   (dbg_beat_cnt),
      .len_err (len_err)
   );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: burst vector table plus hand sequences for arbitration, stalls and reset.
module tb_axi_rd_arbiter;
   import axi_rd_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_araddr = '0, d_araddr = '0, m_araddr;
   logic [7:0]  i_arlen = '0, d_arlen = '0, m_arlen;
   logic [2:0]  i_arsize = 3'd2, d_arsize = 3'd2, m_arsize;
   logic        i_arvalid = 1'b0, d_arvalid = 1'b0, i_arready, d_arready;
   logic [31:0] i_rdata, d_rdata, m_rdata = '0;
   logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
   logic        i_rready = 1'b0, d_rready = 1'b0;
   logic [3:0]  m_arid;
   logic        m_arvalid, m_arready = 1'b0;
   logic        m_rvalid = 1'b0, m_rlast = 1'b0, m_rready;
   logic        len_err;
   logic [1:0]  dbg_state;
   logic [7:0]  dbg_beat_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [7:0]  len;
      int          nbeats;
      logic        exp_err;
   } vec_t;
   vec_t vecs[6];

   axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
      .i_arready(i_arready), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
      .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
      .d_arready(d_arready), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
      .d_rready(d_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
      .len_err(len_err), .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: raise a request on one port
   task automatic req(input logic port, input logic [31:0] addr, input logic [7:0] len);
      if (port) begin
         d_araddr = addr; d_arlen = len; d_arvalid = 1'b1;
      end else begin
         i_araddr = addr; i_arlen = len; i_arvalid = 1'b1;
      end
   endtask

   // driver: play slave for a granted request; optional 3-cycle rready stall before beat stall_at,
   // optional I request armed during the final beat. Returns at the negedge after the last beat.
   task automatic serve(input logic port, input logic [31:0] addr, input logic [7:0] len,
                        input int nbeats, input int stall_at, input logic arm_i, output int seen);
      int t;
      t = 0;
      #1;
      while (!m_arvalid && t < 10) begin
         @(negedge clk); #1; t++;
      end
      chk("ar_wait", 64'(t < 10), 64'd1);
      chk("m_arid", 64'(m_arid), port ? 64'd1 : 64'd0);
      chk("m_araddr", 64'(m_araddr), 64'(addr));
      chk("m_arlen", 64'(m_arlen), 64'(len));
      m_arready = 1'b1;
      #1;
      chk("own_arready", 64'(port ? d_arready : i_arready), 64'd1);
      chk("oth_arready", 64'(port ? i_arready : d_arready), 64'd0);
      @(posedge clk); @(negedge clk);
      m_arready = 1'b0;
      if (port) d_arvalid = 1'b0; else i_arvalid = 1'b0;
      seen = 0;
      for (int b = 0; b < nbeats; b++) begin
         m_rdata  = $urandom;
         m_rvalid = 1'b1;
         m_rlast  = (b == nbeats - 1);
         exp_q.push_back(m_rdata);
         if (b == stall_at) begin
            for (int s = 0; s < 3; s++) begin
               i_rready = 1'b0; d_rready = 1'b0;
               #1;
               chk("stall_m_rready", 64'(m_rready), 64'd0);
               chk("stall_cnt", 64'(dbg_beat_cnt), 64'(b));
               @(posedge clk); @(negedge clk);
            end
         end
         if (port) d_rready = 1'b1; else i_rready = 1'b1;
         if (arm_i && b == nbeats - 1) req(1'b0, 32'h0000_3000, 8'd0);
         #1;
         chk("m_rready", 64'(m_rready), 64'd1);
         chk("oth_rvalid", 64'(port ? i_rvalid : d_rvalid), 64'd0);
         chk("own_rlast", 64'(port ? d_rlast : i_rlast), 64'(b == nbeats - 1));
         if (port ? d_rvalid : i_rvalid) begin
            seen++;
            chk("rdata", 64'(port ? d_rdata : i_rdata), 64'(exp_q.pop_front()));
         end
         @(posedge clk); @(negedge clk);
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
   endtask

   initial begin
      int seen;
      logic first;

      vecs[0] = '{port: 1'b0, addr: 32'h1FC0_0000, len: 8'd7, nbeats: 8, exp_err: 1'b0};
      vecs[1] = '{port: 1'b1, addr: 32'h8000_1000, len: 8'd0, nbeats: 1, exp_err: 1'b0};
      vecs[2] = '{port: 1'b0, addr: 32'h0000_0100, len: 8'd3, nbeats: 4, exp_err: 1'b0};
      vecs[3] = '{port: 1'b1, addr: 32'h0000_2000, len: 8'd3, nbeats: 3, exp_err: 1'b1};
      vecs[4] = '{port: 1'b0, addr: 32'h0000_0040, len: 8'd1, nbeats: 2, exp_err: 1'b1};
      vecs[5] = '{port: 1'b1, addr: 32'h0000_0044, len: 8'd7, nbeats: 8, exp_err: 1'b1};

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_m_rready", 64'(m_rready), 64'd0);
      chk("rst_arready", 64'({i_arready, d_arready}), 64'd0);
      chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
      chk("rst_len_err", 64'(len_err), 64'd0);
      chk("rst_cnt", 64'(dbg_beat_cnt), 64'd0);

      // simultaneous requests right after reset: D first in both builds
      @(negedge clk);
      req(1'b0, 32'h0000_1000, 8'd0);
      req(1'b1, 32'h0000_2000, 8'd0);
      serve(1'b1, 32'h0000_2000, 8'd0, 1, -1, 1'b0, seen);
      chk("simul1_d_beats", 64'(seen), 64'd1);
      serve(1'b0, 32'h0000_1000, 8'd0, 1, -1, 1'b0, seen);
      chk("simul1_i_beats", 64'(seen), 64'd1);

      // single-beat D read, next grant two cycles after the rlast beat
      @(negedge clk);
      req(1'b1, 32'h8000_0000, 8'd0);
      serve(1'b1, 32'h8000_0000, 8'd0, 1, -1, 1'b1, seen);
      #1;
      chk("regrant_c1_arvalid", 64'(m_arvalid), 64'd0);
      @(negedge clk); #1;
      chk("regrant_c2_arvalid", 64'(m_arvalid), 64'd1);
      serve(1'b0, 32'h0000_3000, 8'd0, 1, -1, 1'b0, seen);

      // D wins a grant alone, then simultaneous: round-robin hands the next one to I
      @(negedge clk);
      req(1'b1, 32'h0000_4000, 8'd1);
      serve(1'b1, 32'h0000_4000, 8'd1, 2, -1, 1'b0, seen);
      @(negedge clk);
      req(1'b0, 32'h0000_5000, 8'd0);
      req(1'b1, 32'h0000_6000, 8'd0);
`ifdef ARB_RR_EN
      first = 1'b0;
`else
      first = 1'b1;
`endif
      serve(first, first ? 32'h0000_6000 : 32'h0000_5000, 8'd0, 1, -1, 1'b0, seen);
      serve(!first, first ? 32'h0000_5000 : 32'h0000_6000, 8'd0, 1, -1, 1'b0, seen);
      chk("simul2_second_beats", 64'(seen), 64'd1);

      // requester withdraws before the AR handshake
      @(negedge clk);
      req(1'b0, 32'h0000_7000, 8'd3);
      @(negedge clk); #1;
      chk("abort_arvalid_up", 64'(m_arvalid), 64'd1);
      i_arvalid = 1'b0;
      #1;
      chk("abort_arvalid_down", 64'(m_arvalid), 64'd0);
      chk("abort_arready", 64'(i_arready), 64'd0);
      @(negedge clk); #1;
      chk("abort_state", 64'(dbg_state), 64'(IDLE));
      chk("abort_rvalid", 64'(i_rvalid), 64'd0);

      // rready stall mid-burst
      @(negedge clk);
      req(1'b0, 32'h0000_8000, 8'd3);
      serve(1'b0, 32'h0000_8000, 8'd3, 4, 2, 1'b0, seen);
      chk("stall_beats", 64'(seen), 64'd4);
      chk("stall_len_err", 64'(len_err), 64'd0);

      // vector table: bursts, short-rlast error and its stickiness
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         req(vecs[v].port, vecs[v].addr, vecs[v].len);
         serve(vecs[v].port, vecs[v].addr, vecs[v].len, vecs[v].nbeats, -1, 1'b0, seen);
         #1;
         chk($sformatf("vec%0d_beats", v), 64'(seen), 64'(vecs[v].nbeats));
         chk($sformatf("vec%0d_len_err", v), 64'(len_err), 64'(vecs[v].exp_err));
         chk($sformatf("vec%0d_state", v), 64'(dbg_state), 64'(IDLE));
      end

      // reset after beat 2 of an 8-beat I burst
      @(negedge clk);
      req(1'b0, 32'h0000_9000, 8'd7);
      @(negedge clk);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      i_arvalid = 1'b0;
      m_rvalid  = 1'b1;
      i_rready  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("mid_cnt", 64'(dbg_beat_cnt), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_state", 64'(dbg_state), 64'(IDLE));
      chk("mid_m_rready", 64'(m_rready), 64'd0);
      chk("mid_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
      chk("mid_m_arvalid", 64'(m_arvalid), 64'd0);
      chk("mid_len_err", 64'(len_err), 64'd0);
      m_rvalid = 1'b0;
      i_rready = 1'b0;
      @(negedge clk);
      req(1'b0, 32'h1FC0_0040, 8'd7);
      serve(1'b0, 32'h1FC0_0040, 8'd7, 8, -1, 1'b0, seen);
      #1;
      chk("post_rst_beats", 64'(seen), 64'd8);
      chk("post_rst_len_err", 64'(len_err), 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32; AR address width on all ports.
REQ-002 Parameter DATA_W, default 32; R data width on all ports.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_araddr/d_araddr  input  ADDR_W  instruction/data-cache read address.
REQ-006 i_arlen/d_arlen  input  8  burst length minus one.
REQ-007 i_arsize/d_arsize  input  3  beat size.
REQ-008 i_arvalid/d_arvalid  input  1  requester AR valid.
REQ-009 i_arready/d_arready  output  1  requester AR ready.
REQ-010 i_rdata/d_rdata  output  DATA_W  returned beat.
REQ-011 i_rvalid/d_rvalid, i_rlast/d_rlast  output  1  beat valid, last beat.
REQ-012 i_rready/d_rready  input  1  requester R ready.
REQ-013 m_arid  output  4  transaction ID: 0 = I-port, 1 = D-port.
REQ-014 m_araddr/m_arlen/m_arsize/m_arvalid  output  ADDR_W/8/3/1  shared AR master.
REQ-015 m_arready  input  1  slave AR ready.
REQ-016 m_rdata/m_rvalid/m_rlast  input  DATA_W/1/1  shared R channel.
REQ-017 m_rready  output  1  master R ready.
REQ-018 len_err  output  1  sticky flag: rlast/beat-count mismatch.

Function
REQ-019 FSM states IDLE, AR, R; exactly one read transaction outstanding at any time.
REQ-020 IDLE: if any arvalid, register the grant (owner = I or D) and go to AR next cycle; arvalid-to-m_arvalid latency is 1 cycle.
REQ-021 Arbitration with both requesting in the same IDLE cycle: D-port wins (fixed priority), unless REQ-033 applies.
REQ-022 AR: m_ar* = owner's AR fields, m_arvalid = owner's arvalid; owner's arready = m_arready; non-owner arready = 0.
REQ-023 AR: on m_arvalid & m_arready, load beat counter = 0, latch arlen into expected length, and go to R.
REQ-024 AR: if owner drops arvalid before the handshake, return to IDLE with no beat issued.
REQ-025 R: m_rdata/m_rvalid/m_rlast route to owner only; m_rready = owner's rready; non-owner rvalid = 0.
REQ-026 R: each m_rvalid & m_rready beat increments the counter (8-bit, no wrap beyond 255).
REQ-027 R: beat with m_rlast returns to IDLE on the next edge; a new grant is possible the cycle after.
REQ-028 len_err sets when m_rlast arrives at counter != latched arlen, or when counter == arlen without m_rlast; it clears only on rst.
REQ-029 rdata outputs are driven from m_rdata unconditionally; only valid/last bits are gated.
REQ-030 Requester AR fields must hold stable while arvalid is high (AXI rule); the arbiter does not capture them.

Reset
REQ-031 rst: state = IDLE, owner = I, counter = 0, len_err = 0, last-winner = I; all valid/ready outputs 0.
REQ-032 rst asserted mid-transaction: FSM returns to IDLE next edge, and remaining in-flight beats are discarded (rready 0).

Configuration
REQ-033 ARB_RR_EN defined: round-robin; on simultaneous requests the port that did not win last grant wins. Last-winner updates on each AR handshake. Undefined: fixed D-priority per REQ-021, and the last-winner register is absent.

Structure
REQ-034 Shared package holds the arb_state_t enum (IDLE/AR/R), the ID constants ARID_I = 4'd0 and ARID_D = 4'd1, and the owner_t type.
REQ-035 One sub-module, axi_rd_beat_chk, holds the beat counter and len_err logic; all other logic stays flat.

Verification
REQ-036 Single I request, araddr 0x1FC00000, arlen 7, slave returns 8 beats with rlast on beat 8 -> m_arid 0, i_rvalid pulses 8 times, d_rvalid stays 0, len_err = 0, FSM back in IDLE.
REQ-037 I and D assert arvalid in the same cycle, without ARB_RR_EN -> D served first, then I; with ARB_RR_EN and last winner D -> I served first.
REQ-038 D request with arlen 0 (uncached) -> one beat with rlast, m_arid 1, and a new grant 2 cycles after the rlast beat.
REQ-039 arlen 3, slave asserts rlast on beat 3 -> len_err = 1 and stays 1 through subsequent good bursts until rst.
REQ-040 Owner deasserts rready for 3 cycles mid-burst -> m_rready = 0 for those cycles, no beat lost, counter unchanged.
REQ-041 rst asserted after beat 2 of an arlen 7 burst -> all outputs 0 the next cycle, and a following I request completes normally.
